// File: rtl/noc_credit_switch_allocator_if.sv
// Allocator-side bundle: input FIFO heads and pops, output link writes, credit returns.
// The master drives FIFO heads and credits; the slave is the allocator.
interface noc_credit_switch_allocator_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [2:0]         in_valid;
    logic [3*WIDTH-1:0] in_data;
    logic [2:0]         pop;
    logic [3*WIDTH-1:0] out_data;
    logic [2:0]         out_write;
    logic [2:0]         credit_in;
    logic [2:0]         credit_err;

    modport master (
        output in_valid, in_data, credit_in,
        input  pop, out_data, out_write, credit_err
    );

    modport slave (
        input  in_valid, in_data, credit_in,
        output pop, out_data, out_write, credit_err
    );
endinterface

// File: rtl/noc_credit_switch_allocator.sv
// Three-port (E/W/L) switch allocator: address routing, per-output round-robin arbitration
// gated by downstream credit counters, combinational FIFO pops and registered link writes.
module noc_credit_switch_allocator #(
    parameter int unsigned WIDTH    = 16,
    parameter logic [1:0]  LOCAL_IP = 2'b00,
    parameter int unsigned CREDITS  = 4
) (
    input logic                          clk,
    input logic                          reset,
    noc_credit_switch_allocator_if.slave sw
);
    localparam int unsigned  CW        = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CRED_INIT = CW'(CREDITS);
    localparam logic [CW-1:0] CRED_ONE  = CW'(1);

    logic [WIDTH-1:0]   w_flit    [3];
    logic [1:0]         w_route   [3];
    logic [2:0]         w_req;
    logic [2:0]         w_inv;
    logic [2:0]         w_gnt_vld;
    logic [1:0]         w_gnt_idx [3];
    logic [2:0]         w_in_gnt;
    logic [1:0]         w_idx;

    logic [CW-1:0]      r_credit  [3];
    logic [1:0]         r_rr      [3];
    logic [3*WIDTH-1:0] r_out_data;
    logic [2:0]         r_out_write;
    logic [2:0]         r_credit_err;

    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    // Output index: 0=E, 1=W, 2=L.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_flit[i] = sw.in_data[i*WIDTH +: WIDTH];
            w_req[i]  = sw.in_valid[i] & w_flit[i][0];
            w_inv[i]  = sw.in_valid[i] & ~w_flit[i][0];
            if (w_flit[i][2:1] == LOCAL_IP) begin
                w_route[i] = 2'd2;
            end else if (w_flit[i][2:1] > LOCAL_IP) begin
                w_route[i] = 2'd0;
            end else begin
                w_route[i] = 2'd1;
            end
        end
    end

    always_comb begin
        w_gnt_vld = '0;
        w_in_gnt  = '0;
        w_idx     = '0;
        for (int o = 0; o < 3; o++) begin
            w_gnt_idx[o] = '0;
            if (r_credit[o] != '0) begin
                for (int k = 0; k < 3; k++) begin
                    w_idx = mod3_add(r_rr[o], 2'(k));
                    if (!w_gnt_vld[o] && w_req[w_idx] && (w_route[w_idx] == 2'(o))) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt_idx[o] = w_idx;
                    end
                end
            end
            if (w_gnt_vld[o]) begin
                w_in_gnt[w_gnt_idx[o]] = 1'b1;
            end
        end
    end

    // Invalid heads are discarded immediately so they never block a FIFO.
    assign sw.pop        = reset ? 3'b000 : (w_inv | w_in_gnt);
    assign sw.out_data   = r_out_data;
    assign sw.out_write  = r_out_write;
    assign sw.credit_err = r_credit_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int o = 0; o < 3; o++) begin
                r_credit[o] <= CRED_INIT;
                r_rr[o]     <= '0;
            end
            r_out_data   <= '0;
            r_out_write  <= '0;
            r_credit_err <= '0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                if (w_gnt_vld[o]) begin
                    r_out_data[o*WIDTH +: WIDTH] <= w_flit[w_gnt_idx[o]];
                    r_out_write[o]               <= 1'b1;
                    r_rr[o]                      <= mod3_add(w_gnt_idx[o], 2'd1);
                end else begin
                    r_out_data[o*WIDTH +: WIDTH] <= '0;
                    r_out_write[o]               <= 1'b0;
                end
                // Issue and return in the same cycle cancel out.
                if (w_gnt_vld[o] && !sw.credit_in[o]) begin
                    r_credit[o] <= r_credit[o] - CRED_ONE;
                end else if (!w_gnt_vld[o] && sw.credit_in[o]) begin
                    if (r_credit[o] == CRED_INIT) begin
                        r_credit_err[o] <= 1'b1;
                    end else begin
                        r_credit[o] <= r_credit[o] + CRED_ONE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_noc_credit_switch_allocator.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level
// reference model of routing, round-robin arbitration and credit accounting.
module tb_noc_credit_switch_allocator;
    localparam int unsigned W   = 16;
    localparam int          CRI = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    noc_credit_switch_allocator_if #(.WIDTH(W)) sw ();

    noc_credit_switch_allocator #(
        .WIDTH    (W),
        .LOCAL_IP (2'b01),
        .CREDITS  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    int          m_credit [3];
    int          m_rr     [3];
    logic [2:0]  m_err;
    logic [2:0]  e_wr;
    logic [47:0] e_data;
    int          nw;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Output index for a flit with LOCAL_IP=1: 0=E, 1=W, 2=L.
    function automatic int route(input logic [15:0] f);
        int dst;
        dst = int'(f[2:1]);
        if (dst == 1) return 2;
        else if (dst > 1) return 0;
        else return 1;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < 3; o++) begin
            m_credit[o] = CRI;
            m_rr[o]     = 0;
        end
        m_err = '0;
    endtask

    task automatic cycle(input logic [2:0] v, input logic [47:0] d, input logic [2:0] ci);
        logic [2:0]  exp_pop;
        logic [2:0]  issue;
        logic [15:0] f;
        int          idx;
        sw.in_valid  = v;
        sw.in_data   = d;
        sw.credit_in = ci;
        exp_pop = '0;
        issue   = '0;
        e_wr    = '0;
        e_data  = '0;
        for (int i = 0; i < 3; i++) begin
            f = d[i*16 +: 16];
            if (v[i] && !f[0]) exp_pop[i] = 1'b1;
        end
        for (int o = 0; o < 3; o++) begin
            if (m_credit[o] > 0) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (m_rr[o] + k) % 3;
                    f   = d[idx*16 +: 16];
                    if (!issue[o] && v[idx] && f[0] && route(f) == o) begin
                        issue[o]             = 1'b1;
                        exp_pop[idx]         = 1'b1;
                        e_wr[o]              = 1'b1;
                        e_data[o*16 +: 16]   = f;
                        m_rr[o]              = (idx + 1) % 3;
                    end
                end
            end
        end
        @(negedge clk);
        chk("pop", 64'(sw.pop), 64'(exp_pop));
        @(posedge clk);
        #1;
        for (int o = 0; o < 3; o++) begin
            m_credit[o] = m_credit[o] - int'(issue[o]) + int'(ci[o]);
            if (m_credit[o] > CRI) begin
                m_credit[o] = CRI;
                m_err[o]    = 1'b1;
            end
        end
        chk("out_write", 64'(sw.out_write), 64'(e_wr));
        chk("out_data", 64'(sw.out_data), 64'(e_data));
        chk("credit_err", 64'(sw.credit_err), 64'(m_err));
    endtask

    // Asserted away from any clock edge so the clearing is seen as asynchronous.
    task automatic do_reset();
        sw.in_valid  = 3'b111;
        sw.in_data   = {3{16'h0005}};
        sw.credit_in = '0;
        reset        = 1'b1;
        #2;
        chk("rst_pop", 64'(sw.pop), 64'(0));
        chk("rst_write", 64'(sw.out_write), 64'(0));
        chk("rst_data", 64'(sw.out_data), 64'(0));
        chk("rst_err", 64'(sw.credit_err), 64'(0));
        sw.in_valid = '0;
        sw.in_data  = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    initial begin
        sw.in_valid  = '0;
        sw.in_data   = '0;
        sw.credit_in = '0;
        model_reset();
        #1;
        do_reset();

        // Single flit L -> E.
        cycle(3'b100, {16'h0005, 16'h0000, 16'h0000}, 3'b000);
        chk("single_wr", 64'(sw.out_write), 64'(3'b001));
        chk("single_data", 64'(sw.out_data[15:0]), 64'(16'h0005));
        cycle(3'b000, '0, 3'b000);

        // Three-way contention for Local.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(3'b111, {3{16'h0003}}, 3'b000);
        cycle(3'b000, '0, 3'b000);

        // Credit exhaustion then one returned credit.
        do_reset();
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            cycle(3'b100, {16'h0005, 32'h0}, 3'b000);
            nw += int'(sw.out_write[0]);
        end
        chk("exhaust_writes", 64'(nw), 64'(4));
        nw = 0;
        cycle(3'b100, {16'h0005, 32'h0}, 3'b001);
        nw += int'(sw.out_write[0]);
        for (int c = 0; c < 3; c++) begin
            cycle(3'b100, {16'h0005, 32'h0}, 3'b000);
            nw += int'(sw.out_write[0]);
        end
        chk("refill_writes", 64'(nw), 64'(1));

        // Issue and return together at credit 1; then an invalid head.
        do_reset();
        for (int c = 0; c < 3; c++) cycle(3'b100, {16'h0005, 32'h0}, 3'b000);
        cycle(3'b100, {16'h0005, 32'h0}, 3'b001);
        cycle(3'b100, {16'h0005, 32'h0}, 3'b000);
        chk("simul_wr", 64'(sw.out_write), 64'(3'b001));
        cycle(3'b001, {32'h0, 16'h0004}, 3'b000);
        chk("invalid_nowr", 64'(sw.out_write), 64'(3'b000));

        // Credit overflow on W, sticky flag, W credits still 4.
        do_reset();
        cycle(3'b000, '0, 3'b010);
        chk("ovf_err", 64'(sw.credit_err), 64'(3'b010));
        for (int c = 0; c < 5; c++) cycle(3'b100, {16'h0001, 32'h0}, 3'b000);
        chk("ovf_sticky", 64'(sw.credit_err), 64'(3'b010));

        // Reset while a write is on the link.
        cycle(3'b100, {16'h0005, 32'h0}, 3'b000);
        chk("pre_rst_wr", 64'(sw.out_write), 64'(3'b001));
        do_reset();
        for (int c = 0; c < 5; c++) cycle(3'b100, {16'h0005, 32'h0}, 3'b000);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            logic [47:0] d;
            logic [2:0]  ci;
            for (int i = 0; i < 3; i++) begin
                d[i*16 +: 16] = {13'($urandom), 2'($urandom_range(0, 3)),
                                 1'($urandom_range(0, 3) != 0)};
                ci[i]         = ($urandom_range(0, 3) == 0);
            end
            cycle(3'($urandom), d, ci);
            if (c == 200) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
